// File: rtl/or_gate_unit.sv
// Bitwise two-input OR with a combinational result and a one-cycle registered result.
// Truth-table coverage counters on bit 0 record which input combinations were sampled.
module or_gate_unit #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    input  logic             clr,
    output logic [WIDTH-1:0] y,
    output logic             any_one,
    output logic [WIDTH-1:0] y_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] cnt_00,
    output logic [CNT_W-1:0] cnt_01,
    output logic [CNT_W-1:0] cnt_10,
    output logic [CNT_W-1:0] cnt_11,
    output logic             covered
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] y_reg_q, y_reg_d;
    logic             vld_q, vld_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [1:0]       sel;

    assign y       = a | b;
    assign any_one = |y;
    assign sel     = {a[0], b[0]};

    always_comb begin
        y_reg_d = y_reg_q;
        vld_d   = 1'b0;
        if (in_valid) begin
            y_reg_d = a | b;
            vld_d   = 1'b1;
        end
    end

    // clr beats in_valid for the counters; the registered path is unaffected by clr
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        if (clr) begin
            for (int i = 0; i < 4; i++) begin
                cnt_d[i] = '0;
            end
        end else if (in_valid) begin
            if (cnt_q[sel] != CNT_MAX) begin
                cnt_d[sel] = cnt_q[sel] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_reg_q <= '0;
            vld_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            y_reg_q <= y_reg_d;
            vld_q   <= vld_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign y_q       = y_reg_q;
    assign out_valid = vld_q;
    assign cnt_00    = cnt_q[0];
    assign cnt_01    = cnt_q[1];
    assign cnt_10    = cnt_q[2];
    assign cnt_11    = cnt_q[3];
    assign covered   = (cnt_q[0] != '0) && (cnt_q[1] != '0) &&
                       (cnt_q[2] != '0) && (cnt_q[3] != '0);

endmodule

// File: tb/tb_or_gate_unit.sv
// Directed bench for or_gate_unit: truth-table vectors plus clocked corner-case sequences.
module tb_or_gate_unit;

    logic       clk = 1'b0;
    logic       rst, in_valid, clr;
    logic [0:0] a, b;

    logic [0:0] y, y_q, s_y, s_y_q;
    logic       any_one, out_valid, covered;
    logic       s_any_one, s_out_valid, s_covered;
    logic [7:0] cnt_00, cnt_01, cnt_10, cnt_11;
    logic [1:0] s_cnt_00, s_cnt_01, s_cnt_10, s_cnt_11;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic a;
        logic b;
        logic y;
        logic any;
    } vec_t;

    vec_t tt [4];

    always #5 clk = ~clk;

    or_gate_unit #(.WIDTH(1), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid), .clr(clr),
        .y(y), .any_one(any_one), .y_q(y_q), .out_valid(out_valid),
        .cnt_00(cnt_00), .cnt_01(cnt_01), .cnt_10(cnt_10), .cnt_11(cnt_11),
        .covered(covered)
    );

    or_gate_unit #(.WIDTH(1), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid), .clr(clr),
        .y(s_y), .any_one(s_any_one), .y_q(s_y_q), .out_valid(s_out_valid),
        .cnt_00(s_cnt_00), .cnt_01(s_cnt_01), .cnt_10(s_cnt_10), .cnt_11(s_cnt_11),
        .covered(s_covered)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnts(input string tag, input int c00, input int c01, input int c10, input int c11);
        chk({tag, " cnt_00"}, 32'(cnt_00), c00);
        chk({tag, " cnt_01"}, 32'(cnt_01), c01);
        chk({tag, " cnt_10"}, 32'(cnt_10), c10);
        chk({tag, " cnt_11"}, 32'(cnt_11), c11);
    endtask

    initial begin
        int sat_exp [5];
        tt[0] = '{a: 1'b0, b: 1'b0, y: 1'b0, any: 1'b0};
        tt[1] = '{a: 1'b0, b: 1'b1, y: 1'b1, any: 1'b1};
        tt[2] = '{a: 1'b1, b: 1'b0, y: 1'b1, any: 1'b1};
        tt[3] = '{a: 1'b1, b: 1'b1, y: 1'b1, any: 1'b1};
        sat_exp = '{1, 2, 3, 3, 3};

        rst = 1'b1; in_valid = 1'b0; clr = 1'b0; a = 1'b0; b = 1'b0;

        // combinational truth table, observed within the same 5-unit step
        for (int i = 0; i < 4; i++) begin
            a = tt[i].a;
            b = tt[i].b;
            #1;
            chk($sformatf("comb y[%0d]", i), 32'(y), 32'(tt[i].y));
            chk($sformatf("comb any_one[%0d]", i), 32'(any_one), 32'(tt[i].any));
            #4;
        end

        repeat (2) tick();
        chk("reset y_q", 32'(y_q), 0);
        chk("reset out_valid", 32'(out_valid), 0);
        chk("reset covered", 32'(covered), 0);
        chk_cnts("reset", 0, 0, 0, 0);

        rst = 1'b0; a = 1'b0; b = 1'b1; in_valid = 1'b1;
        tick();
        chk("reg y_q", 32'(y_q), 1);
        chk("reg out_valid", 32'(out_valid), 1);
        chk("reg cnt_01", 32'(cnt_01), 1);
        in_valid = 1'b0; b = 1'b0;
        tick();
        chk("idle out_valid", 32'(out_valid), 0);
        chk("idle y_q hold", 32'(y_q), 1);

        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk_cnts("clr", 0, 0, 0, 0);

        // one combination per cycle; covered must stay low until the last is counted
        for (int i = 0; i < 4; i++) begin
            a = tt[i].a; b = tt[i].b; in_valid = 1'b1;
            chk($sformatf("cov pre covered[%0d]", i), 32'(covered), 0);
            tick();
            chk($sformatf("cov y_q[%0d]", i), 32'(y_q), 32'(tt[i].y));
            chk($sformatf("cov out_valid[%0d]", i), 32'(out_valid), 1);
        end
        chk_cnts("cov", 1, 1, 1, 1);
        chk("cov covered", 32'(covered), 1);

        clr = 1'b1; in_valid = 1'b1; a = 1'b1; b = 1'b1;
        tick();
        clr = 1'b0;
        chk_cnts("clrprio", 0, 0, 0, 0);
        chk("clrprio covered", 32'(covered), 0);
        chk("clrprio y_q", 32'(y_q), 1);
        chk("clrprio out_valid", 32'(out_valid), 1);

        a = 1'b0; b = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("sat cnt_00[%0d]", i), 32'(s_cnt_00), sat_exp[i]);
            chk($sformatf("sat others[%0d]", i), 32'({s_cnt_01, s_cnt_10, s_cnt_11}), 0);
            chk($sformatf("wide cnt_00[%0d]", i), 32'(cnt_00), i + 1);
            chk($sformatf("sat y_q[%0d]", i), 32'(y_q), 0);
        end

        a = 1'b1; b = 1'b0;
        tick();
        chk("mid y_q", 32'(y_q), 1);
        chk("mid out_valid", 32'(out_valid), 1);
        rst = 1'b1;
        tick();
        chk("rstmid y_q", 32'(y_q), 0);
        chk("rstmid out_valid", 32'(out_valid), 0);
        chk("rstmid y", 32'(y), 1);
        chk("rstmid any_one", 32'(any_one), 1);
        chk("rstmid covered", 32'(covered), 0);
        chk_cnts("rstmid", 0, 0, 0, 0);
        chk("rstmid sat cnt_00", 32'(s_cnt_00), 0);
        rst = 1'b0;
        tick();
        chk("post-rst out_valid", 32'(out_valid), 1);
        chk("post-rst cnt_10", 32'(cnt_10), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
